// File: rtl/nec_ir_pkg.sv
// rtl/nec_ir_pkg.sv - shared types and constants for the NEC IR receiver
//
// Purpose: receiver state encoding, nominal NEC tick counts at a 16 kHz
// tick and the byte offsets of the fields inside the 32-bit frame.
// Ports: none (package).

package nec_ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_REP_MARK,
        S_CHECK
    } nec_state_t;

    // Nominal NEC timings in 16 kHz ticks (62.5 us each).
    localparam int NEC_LEAD_MARK_NOM  = 144;  // 9.0 ms
    localparam int NEC_LEAD_SPACE_NOM = 72;   // 4.5 ms
    localparam int NEC_REP_SPACE_NOM  = 36;   // 2.25 ms
    localparam int NEC_BIT_MARK_NOM   = 9;    // 562.5 us
    localparam int NEC_ZERO_SPACE_NOM = 9;    // 562.5 us
    localparam int NEC_ONE_SPACE_NOM  = 27;   // 1.6875 ms

    // Frame layout, bits received LSB first: {cmd_n, cmd, addr_n, addr}.
    localparam int FRAME_BITS = 32;
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_N_LSB = 8;
    localparam int CMD_LSB    = 16;
    localparam int CMD_N_LSB  = 24;

endpackage

// File: rtl/ir_pulse_timer.sv
// rtl/ir_pulse_timer.sv - IR input synchroniser, edge detector and width counter
//
// Purpose: brings the asynchronous IR line into the slow_clk domain and
// measures how long each level lasts.
// Ports:
//   slow_clk  in   16 kHz tick clock
//   reset     in   asynchronous active-high reset
//   ir_data   in   raw demodulated IR line
//   level     out  synchronised line level
//   ir_edge   out  high for one cycle after the synchronised level changes
//   width     out  ticks since the previous edge; valid as a width when ir_edge is high
//   timeout   out  width counter is saturated

module ir_pulse_timer #(
    parameter bit IDLE_LEVEL = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic             slow_clk,
    input  logic             reset,
    input  logic             ir_data,
    output logic             level,
    output logic             ir_edge,
    output logic [CNT_W-1:0] width,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_1;
    logic             sync_2;
    logic             sync_3;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            sync_1 <= IDLE_LEVEL;
            sync_2 <= IDLE_LEVEL;
            sync_3 <= IDLE_LEVEL;
            cnt    <= '0;
        end else begin
            sync_1 <= ir_data;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            if (ir_edge) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign level   = sync_2;
    assign ir_edge = sync_2 ^ sync_3;
    assign width   = cnt;
    assign timeout = (cnt == CNT_MAX);

endmodule

// File: rtl/nec_ir_receiver.sv
// rtl/nec_ir_receiver.sv - NEC infrared frame receiver with repeat and timeout handling
//
// Purpose: decodes 32-bit NEC frames from mark/space widths, validates the
// complement bytes and reports the {command, address} code.
// Ports:
//   slow_clk       in   16 kHz tick clock
//   reset          in   asynchronous active-high reset
//   ir_data        in   raw demodulated IR line
//   ir_data_array  out  last valid code {cmd, addr}
//   frame_valid    out  one-cycle pulse when ir_data_array updates
//   repeat_valid   out  one-cycle pulse on an accepted repeat code
//   frame_error    out  one-cycle pulse on a timing/check violation or timeout
//   busy           out  registered copy of (state != IDLE), one cycle behind

module nec_ir_receiver
    import nec_ir_pkg::*;
#(
    parameter bit IDLE_LEVEL     = 1'b1,
    parameter int CNT_W          = 8,
    parameter int LEAD_MARK_MIN  = 128,
    parameter int LEAD_MARK_MAX  = 160,
    parameter int LEAD_SPACE_MIN = 64,
    parameter int LEAD_SPACE_MAX = 80,
    parameter int REP_SPACE_MIN  = 30,
    parameter int REP_SPACE_MAX  = 42,
    parameter int BIT_MARK_MIN   = 6,
    parameter int BIT_MARK_MAX   = 13,
    parameter int ZERO_MIN       = 6,
    parameter int ZERO_MAX       = 13,
    parameter int ONE_MIN        = 22,
    parameter int ONE_MAX        = 32,
    parameter bit CHECK_ADDR     = 1'b1
) (
    input  logic        slow_clk,
    input  logic        reset,
    input  logic        ir_data,
    output logic [15:0] ir_data_array,
    output logic        frame_valid,
    output logic        repeat_valid,
    output logic        frame_error,
    output logic        busy
);

    // Every window limit must sit below the saturation value, otherwise a
    // timed-out pulse could be mistaken for an in-window one.
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    if (LEAD_MARK_MIN >= CNT_SAT || LEAD_MARK_MAX >= CNT_SAT ||
        LEAD_SPACE_MIN >= CNT_SAT || LEAD_SPACE_MAX >= CNT_SAT ||
        REP_SPACE_MIN >= CNT_SAT || REP_SPACE_MAX >= CNT_SAT ||
        BIT_MARK_MIN >= CNT_SAT || BIT_MARK_MAX >= CNT_SAT ||
        ZERO_MIN >= CNT_SAT || ZERO_MAX >= CNT_SAT ||
        ONE_MIN >= CNT_SAT || ONE_MAX >= CNT_SAT) begin : g_bad_window
        $error("nec_ir_receiver: timing window limit not below counter saturation");
    end

    if (NEC_LEAD_MARK_NOM < LEAD_MARK_MIN || NEC_LEAD_MARK_NOM > LEAD_MARK_MAX ||
        NEC_LEAD_SPACE_NOM < LEAD_SPACE_MIN || NEC_LEAD_SPACE_NOM > LEAD_SPACE_MAX ||
        NEC_REP_SPACE_NOM < REP_SPACE_MIN || NEC_REP_SPACE_NOM > REP_SPACE_MAX ||
        NEC_BIT_MARK_NOM < BIT_MARK_MIN || NEC_BIT_MARK_NOM > BIT_MARK_MAX ||
        NEC_ZERO_SPACE_NOM < ZERO_MIN || NEC_ZERO_SPACE_NOM > ZERO_MAX ||
        NEC_ONE_SPACE_NOM < ONE_MIN || NEC_ONE_SPACE_NOM > ONE_MAX) begin : g_off_nominal
        $warning("nec_ir_receiver: a timing window excludes the nominal NEC value");
    end

    localparam logic [CNT_W-1:0] LM_LO = CNT_W'(LEAD_MARK_MIN);
    localparam logic [CNT_W-1:0] LM_HI = CNT_W'(LEAD_MARK_MAX);
    localparam logic [CNT_W-1:0] LS_LO = CNT_W'(LEAD_SPACE_MIN);
    localparam logic [CNT_W-1:0] LS_HI = CNT_W'(LEAD_SPACE_MAX);
    localparam logic [CNT_W-1:0] RS_LO = CNT_W'(REP_SPACE_MIN);
    localparam logic [CNT_W-1:0] RS_HI = CNT_W'(REP_SPACE_MAX);
    localparam logic [CNT_W-1:0] BM_LO = CNT_W'(BIT_MARK_MIN);
    localparam logic [CNT_W-1:0] BM_HI = CNT_W'(BIT_MARK_MAX);
    localparam logic [CNT_W-1:0] Z_LO  = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] Z_HI  = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0] O_LO  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] O_HI  = CNT_W'(ONE_MAX);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    function automatic logic in_win(input logic [CNT_W-1:0] w, lo, hi);
        return (w >= lo) && (w <= hi);
    endfunction

    logic             level;
    logic             ir_edge;
    logic             timeout;
    logic [CNT_W-1:0] width;

    ir_pulse_timer #(
        .IDLE_LEVEL (IDLE_LEVEL),
        .CNT_W      (CNT_W)
    ) u_timer (
        .slow_clk (slow_clk),
        .reset    (reset),
        .ir_data  (ir_data),
        .level    (level),
        .ir_edge  (ir_edge),
        .width    (width),
        .timeout  (timeout)
    );

    nec_state_t            state;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] sr;
    logic                  have_frame;

    logic is_mark;
    logic cmd_ok;
    logic addr_ok;
    logic check_pass;

    assign is_mark    = (level != IDLE_LEVEL);
    assign cmd_ok     = ((sr[CMD_LSB +: 8] ^ sr[CMD_N_LSB +: 8]) == 8'hFF);
    assign addr_ok    = ((sr[ADDR_LSB +: 8] ^ sr[ADDR_N_LSB +: 8]) == 8'hFF);
    assign check_pass = cmd_ok && (addr_ok || !CHECK_ADDR);

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            sr            <= '0;
            have_frame    <= 1'b0;
            ir_data_array <= 16'h0000;
            frame_valid   <= 1'b0;
            repeat_valid  <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            frame_valid  <= 1'b0;
            repeat_valid <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= (state != S_IDLE);

            // A saturated counter means the line stopped toggling mid-frame.
            // CHECK is excluded: it always leaves after one cycle on its own.
            if (state != S_IDLE && state != S_CHECK && !ir_edge && timeout) begin
                frame_error <= 1'b1;
                state       <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ir_edge && is_mark) begin
                            state <= S_LEAD_MARK;
                        end
                    end
                    S_LEAD_MARK: begin
                        if (ir_edge) begin
                            if (in_win(width, LM_LO, LM_HI)) begin
                                state <= S_LEAD_SPACE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= S_IDLE;
                            end
                        end
                    end
                    S_LEAD_SPACE: begin
                        if (ir_edge) begin
                            if (in_win(width, LS_LO, LS_HI)) begin
                                bit_cnt <= '0;
                                sr      <= '0;
                                state   <= S_BIT_MARK;
                            end else if (in_win(width, RS_LO, RS_HI)) begin
                                state <= S_REP_MARK;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= S_IDLE;
                            end
                        end
                    end
                    S_BIT_MARK: begin
                        if (ir_edge) begin
                            if (in_win(width, BM_LO, BM_HI)) begin
                                state <= S_BIT_SPACE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= S_IDLE;
                            end
                        end
                    end
                    S_BIT_SPACE: begin
                        if (ir_edge) begin
                            if (in_win(width, Z_LO, Z_HI) || in_win(width, O_LO, O_HI)) begin
                                // Windows are disjoint, so being outside the zero
                                // window here means the bit is a one.
                                sr      <= {!in_win(width, Z_LO, Z_HI), sr[FRAME_BITS-1:1]};
                                bit_cnt <= bit_cnt + 6'd1;
                                state   <= (bit_cnt == LAST_BIT) ? S_CHECK : S_BIT_MARK;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= S_IDLE;
                            end
                        end
                    end
                    S_CHECK: begin
                        // The stop mark is left unmeasured; edges here are ignored.
                        if (check_pass) begin
                            ir_data_array <= {sr[CMD_LSB +: 8], sr[ADDR_LSB +: 8]};
                            frame_valid   <= 1'b1;
                            have_frame    <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    S_REP_MARK: begin
                        if (ir_edge) begin
                            if (!in_win(width, BM_LO, BM_HI)) begin
                                frame_error <= 1'b1;
                            end else if (have_frame) begin
                                repeat_valid <= 1'b1;
                            end
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// tb/tb_nec_ir_receiver.sv - self-checking bench for nec_ir_receiver

module tb_nec_ir_receiver;
    import nec_ir_pkg::*;

    logic slow_clk = 1'b0;
    logic reset    = 1'b1;
    logic ir_data  = 1'b1;

    always #5 slow_clk = ~slow_clk;

    logic [15:0] data_a, data_b;
    logic        fv_a, rv_a, fe_a, busy_a;
    logic        fv_b, rv_b, fe_b, busy_b;

    nec_ir_receiver #(.CHECK_ADDR(1'b1)) dut_a (
        .slow_clk      (slow_clk),
        .reset         (reset),
        .ir_data       (ir_data),
        .ir_data_array (data_a),
        .frame_valid   (fv_a),
        .repeat_valid  (rv_a),
        .frame_error   (fe_a),
        .busy          (busy_a)
    );

    nec_ir_receiver #(.CHECK_ADDR(1'b0)) dut_b (
        .slow_clk      (slow_clk),
        .reset         (reset),
        .ir_data       (ir_data),
        .ir_data_array (data_b),
        .frame_valid   (fv_b),
        .repeat_valid  (rv_b),
        .frame_error   (fe_b),
        .busy          (busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse counters, sampled on the falling edge.
    int fv_cnt_a = 0, rv_cnt_a = 0, fe_cnt_a = 0;
    int fv_cnt_b = 0, rv_cnt_b = 0, fe_cnt_b = 0;

    always @(negedge slow_clk) begin
        if (fv_a) fv_cnt_a++;
        if (rv_a) rv_cnt_a++;
        if (fe_a) fe_cnt_a++;
        if (fv_b) fv_cnt_b++;
        if (rv_b) rv_cnt_b++;
        if (fe_b) fe_cnt_b++;
    end

    int b_fv_a, b_rv_a, b_fe_a, b_fv_b, b_rv_b, b_fe_b;

    task automatic snap();
        b_fv_a = fv_cnt_a; b_rv_a = rv_cnt_a; b_fe_a = fe_cnt_a;
        b_fv_b = fv_cnt_b; b_rv_b = rv_cnt_b; b_fe_b = fe_cnt_b;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // exp_fe: 0 = no error pulse allowed, 1 = at least one error pulse.
    task automatic check_outcome(input string tag,
                                 input int exp_fv_a, input int exp_fe_a, input logic [15:0] exp_a,
                                 input int exp_fv_b, input int exp_fe_b, input logic [15:0] exp_b,
                                 input int exp_rv);
        check({tag, ".fv_a"}, fv_cnt_a - b_fv_a, exp_fv_a);
        check({tag, ".fe_a"}, 32'((fe_cnt_a - b_fe_a) != 0), exp_fe_a);
        check({tag, ".rv_a"}, rv_cnt_a - b_rv_a, exp_rv);
        check({tag, ".data_a"}, data_a, exp_a);
        check({tag, ".fv_b"}, fv_cnt_b - b_fv_b, exp_fv_b);
        check({tag, ".fe_b"}, 32'((fe_cnt_b - b_fe_b) != 0), exp_fe_b);
        check({tag, ".rv_b"}, rv_cnt_b - b_rv_b, exp_rv);
        check({tag, ".data_b"}, data_b, exp_b);
    endtask

    // Holding a level for w+1 cycles makes the receiver measure width w
    // (the counter restarts at 0 on the edge cycle).
    task automatic seg(input logic lvl, input int w);
        ir_data = lvl;
        repeat (w + 1) begin
            @(posedge slow_clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] word, input int lm, input int ls, input int zw,
                        input int ow, input int bad_idx, input int bad_w, input int nbits);
        seg(1'b0, lm);
        seg(1'b1, ls);
        for (int i = 0; i < nbits; i++) begin
            seg(1'b0, NEC_BIT_MARK_NOM);
            seg(1'b1, (i == bad_idx) ? bad_w : (word[i] ? ow : zw));
        end
        if (nbits == 32) begin
            seg(1'b0, NEC_BIT_MARK_NOM);
            seg(1'b1, 40);
        end
    endtask

    task automatic send_nominal(input logic [7:0] addr, input logic [7:0] cmd);
        send({~cmd, cmd, ~addr, addr}, 144, 72, 9, 27, -1, 0, 32);
    endtask

    task automatic send_repeat();
        seg(1'b0, 144);
        seg(1'b1, 36);
        seg(1'b0, 9);
        seg(1'b1, 40);
    endtask

    typedef struct {
        logic [7:0]  addr, addr_n, cmd, cmd_n;
        int          lm, ls, zw, ow, bad_idx, bad_w;
        int          fv_a, fe_a;
        logic [15:0] data_a;
        int          fv_b, fe_b;
        logic [15:0] data_b;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int first_err;
    logic busy_at, busy_after;

    initial begin
        vecs[0] = '{8'h00, 8'hFF, 8'h45, 8'hBA, 144, 72,  9, 27, -1,  0, 1, 0, 16'h4500, 1, 0, 16'h4500};
        vecs[1] = '{8'h00, 8'hFF, 8'h45, 8'h3A, 144, 72,  9, 27, -1,  0, 0, 1, 16'h4500, 0, 1, 16'h4500};
        vecs[2] = '{8'h12, 8'h34, 8'h7E, 8'h81, 144, 72,  9, 27, -1,  0, 0, 1, 16'h4500, 1, 0, 16'h7E12};
        vecs[3] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 144, 72, 13, 22, -1,  0, 1, 0, 16'h3CA5, 1, 0, 16'h3CA5};
        vecs[4] = '{8'h11, 8'hEE, 8'h22, 8'hDD, 127, 72,  9, 27, -1,  0, 0, 1, 16'h3CA5, 0, 1, 16'h3CA5};
        vecs[5] = '{8'h11, 8'hEE, 8'h22, 8'hDD, 128, 72,  9, 27, -1,  0, 1, 0, 16'h2211, 1, 0, 16'h2211};
        vecs[6] = '{8'h66, 8'h99, 8'h55, 8'hAA, 144, 72,  9, 27,  5, 17, 0, 1, 16'h2211, 0, 1, 16'h2211};
        vecs[7] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 144, 64,  6, 32, -1,  0, 1, 0, 16'h00FF, 1, 0, 16'h00FF};
        vecs[8] = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 160, 80,  9, 27, -1,  0, 1, 0, 16'h813C, 1, 0, 16'h813C};

        // Reset state.
        repeat (3) @(posedge slow_clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge slow_clk);
        #1;
        check("reset.data_a", data_a, 16'h0000);
        check("reset.busy_a", busy_a, 1'b0);
        check("reset.pulses_a", {fv_a, rv_a, fe_a}, 3'b000);
        check("reset.data_b", data_b, 16'h0000);

        // Repeat code before any frame: silently ignored.
        snap();
        seg(1'b1, 20);
        send_repeat();
        check_outcome("rep_noframe", 0, 0, 16'h0000, 0, 0, 16'h0000, 0);

        // Table of full frames.
        for (int i = 0; i < NVEC; i++) begin
            snap();
            send({vecs[i].cmd_n, vecs[i].cmd, vecs[i].addr_n, vecs[i].addr},
                 vecs[i].lm, vecs[i].ls, vecs[i].zw, vecs[i].ow,
                 vecs[i].bad_idx, vecs[i].bad_w, 32);
            check_outcome($sformatf("vec%0d", i),
                          vecs[i].fv_a, vecs[i].fe_a, vecs[i].data_a,
                          vecs[i].fv_b, vecs[i].fe_b, vecs[i].data_b, 0);
        end

        // Repeat code after a good frame.
        snap();
        send_repeat();
        check_outcome("rep_after", 0, 0, 16'h813C, 0, 0, 16'h813C, 1);

        // Line stuck in mark after bit 10: error when the counter saturates.
        // Mark driven at P0; edge acted on at P3; counter reaches 255 after
        // P258; the error pulse is registered at P259.
        snap();
        send({8'h69, 8'h96, 8'hA5, 8'h5A}, 144, 72, 9, 27, -1, 0, 10);
        ir_data   = 1'b0;
        first_err = -1;
        busy_at   = 1'b0;
        busy_after = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge slow_clk);
            #1;
            if (first_err < 0 && fe_a) begin
                first_err = k;
                busy_at   = busy_a;
            end else if (first_err >= 0 && k == first_err + 1) begin
                busy_after = busy_a;
                break;
            end
        end
        check("timeout.cycle", first_err, 259);
        check("timeout.busy_at_err", busy_at, 1'b1);
        check("timeout.busy_after", busy_after, 1'b0);
        check("timeout.err_count", fe_cnt_a - b_fe_a, 1);
        seg(1'b1, 40);
        snap();
        send_nominal(8'h5A, 8'h96);
        check_outcome("after_timeout", 1, 0, 16'h965A, 1, 0, 16'h965A, 0);

        // Asynchronous reset in the middle of bit 20.
        send({8'h69, 8'h96, 8'hA5, 8'h5A}, 144, 72, 9, 27, -1, 0, 20);
        check("midreset.busy_before", busy_a, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset.data_a", data_a, 16'h0000);
        check("midreset.data_b", data_b, 16'h0000);
        check("midreset.busy_a", busy_a, 1'b0);
        check("midreset.pulses_a", {fv_a, rv_a, fe_a}, 3'b000);
        ir_data = 1'b1;
        repeat (3) @(posedge slow_clk);
        #1;
        reset = 1'b0;
        seg(1'b1, 20);
        snap();
        send_nominal(8'h00, 8'h45);
        check_outcome("after_reset", 1, 0, 16'h4500, 1, 0, 16'h4500, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
